// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic light sequencer.
//   state_t          FSM state encoding
//   LAMP_*           lamp command encodings (L3 uses all 3 bits, L1/L2 use [1:0])
//   lamp_set_t       one set of lamp commands {l3, l2, l1}
//   default_lamps()  lamp commands of a phase index (fixed per phase)
//   default_dur()    power-up duration of a phase index, in ticks
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_EXT,
    ST_CLEAR,
    ST_FLASH
  } state_t;

  localparam logic [2:0] LAMP_RED      = 3'd0;
  localparam logic [2:0] LAMP_YEL      = 3'd1;
  localparam logic [2:0] LAMP_GRN      = 3'd2;
  localparam logic [2:0] LAMP_GRN_LEFT = 3'd3;
  localparam logic [2:0] LAMP_GRN_YEL  = 3'd4;

  typedef struct packed {
    logic [2:0] l3;
    logic [1:0] l2;
    logic [1:0] l1;
  } lamp_set_t;

  localparam lamp_set_t ALL_RED  = '{l3: 3'd0, l2: 2'd0, l1: 2'd0};
  localparam lamp_set_t FLASH_ON = '{l3: 3'd1, l2: 2'd1, l1: 2'd1};

  function automatic lamp_set_t default_lamps(input int idx);
    lamp_set_t l;
    l = ALL_RED;
    case (idx)
      0: l.l3 = LAMP_GRN_LEFT;
      1: l.l3 = LAMP_GRN_YEL;
      2: begin
        l.l3 = LAMP_GRN;
        l.l2 = LAMP_GRN[1:0];
      end
      3: begin
        l.l3 = LAMP_YEL;
        l.l2 = LAMP_YEL[1:0];
      end
      4: l.l1 = LAMP_GRN[1:0];
      5: l.l1 = LAMP_YEL[1:0];
      default: l = ALL_RED;
    endcase
    return l;
  endfunction

  function automatic int default_dur(input int idx);
    case (idx)
      0: return 40;
      1: return 6;
      2: return 80;
      3: return 6;
      4: return 60;
      5: return 6;
      default: return 10;
    endcase
  endfunction

endpackage

// File: rtl/traffic_seq_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every PRESCALE clk cycles.
//   clk    system clock
//   reset  asynchronous active-low reset
//   tick   high for one clk cycle out of every PRESCALE
// The counter resets to 0, so the first tick lands on the first cycle after
// reset release; PRESCALE=1 gives a tick on every cycle.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int P  = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] TOP = CW'(P - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= TOP;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/traffic_seq.sv
// traffic_seq: phase-table traffic light sequencer with pedestrian extension,
// all-red clearance and flashing-yellow mode.
//   clk, reset        clock, asynchronous active-low reset
//   cfg_we/idx/dur    write a new duration (ticks) into the phase table
//   ped_req           pedestrian request, pulse or level (sticky until served)
//   flash_en          request flashing-yellow mode
//   L1_cmd, L2_cmd    2-bit registered lamp commands
//   L3_cmd            3-bit registered lamp command
//   phase_idx         current phase
//   ped_ack           one-cycle pulse when the extension starts
//   phase_end         one-cycle pulse after the last tick of a phase
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | all red, waits for the first tick after reset
// ST_RUN   | drives phase_idx lamps for its table duration
// ST_EXT   | holds PED_PHASE lamps for PED_EXT extra ticks
// ST_CLEAR | all red for CLR_TICKS, then FLASH or phase 0
// ST_FLASH | all lamps toggle yellow/red every tick
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int NUM_PHASE = 6,
  parameter int CNT_W     = 8,
  parameter int PRESCALE  = 1,
  parameter int PED_PHASE = 2,
  parameter int PED_EXT   = 20,
  parameter int CLR_TICKS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_PHASE)-1:0] cfg_idx,
  input  logic [CNT_W-1:0]             cfg_dur,
  input  logic                         ped_req,
  input  logic                         flash_en,
  output logic [1:0]                   L1_cmd,
  output logic [1:0]                   L2_cmd,
  output logic [2:0]                   L3_cmd,
  output logic [$clog2(NUM_PHASE)-1:0] phase_idx,
  output logic                         ped_ack,
  output logic                         phase_end
);

  localparam int IW = $clog2(NUM_PHASE);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_PHASE - 1);
  localparam logic [IW-1:0]    PED_IDX  = IW'(PED_PHASE);
  // Counters hold "ticks remaining minus one"; a phase ends on the tick
  // where the counter is already zero.
  localparam logic [CNT_W-1:0] PED_LOAD = CNT_W'((PED_EXT > 0) ? PED_EXT - 1 : 0);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'((CLR_TICKS > 0) ? CLR_TICKS - 1 : 0);

  function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] d);
    // a stored duration of 0 still runs for one tick
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  logic tick;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Duration table; read only when a phase is entered, so writes never
  // disturb the count already running.
  logic [CNT_W-1:0] dur_tbl [NUM_PHASE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PHASE; i++) begin
        dur_tbl[i] <= CNT_W'(default_dur(i));
      end
    end else if (cfg_we && (int'(cfg_idx) < NUM_PHASE)) begin
      dur_tbl[cfg_idx] <= cfg_dur;
    end
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ped_pend;
  logic             clr_to_flash;
  lamp_set_t        lamps;
  logic [IW-1:0]    nxt_idx;
  lamp_set_t        nxt_lamps;
  lamp_set_t        first_lamps;

  assign nxt_idx     = (phase_idx == LAST_IDX) ? '0 : phase_idx + IW'(1);
  assign nxt_lamps   = default_lamps(int'(nxt_idx));
  assign first_lamps = default_lamps(0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_INIT;
      cnt          <= '0;
      phase_idx    <= '0;
      lamps        <= ALL_RED;
      ped_ack      <= 1'b0;
      phase_end    <= 1'b0;
      ped_pend     <= 1'b0;
      clr_to_flash <= 1'b0;
    end else begin
      ped_ack   <= 1'b0;
      phase_end <= 1'b0;
      if (ped_req) ped_pend <= 1'b1;

      if (tick) begin
        unique case (state)
          ST_INIT: begin
            state     <= ST_RUN;
            phase_idx <= '0;
            cnt       <= load_of(dur_tbl[0]);
            lamps     <= first_lamps;
          end

          ST_RUN, ST_EXT: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              if (state == ST_RUN) phase_end <= 1'b1;
              if (flash_en) begin
                // pending pedestrian request is deliberately kept here
                state        <= ST_CLEAR;
                cnt          <= CLR_LOAD;
                lamps        <= ALL_RED;
                clr_to_flash <= 1'b1;
              end else if (state == ST_RUN && phase_idx == PED_IDX && ped_pend) begin
                state    <= ST_EXT;
                cnt      <= PED_LOAD;
                ped_ack  <= 1'b1;
                ped_pend <= ped_req;
              end else begin
                state     <= ST_RUN;
                phase_idx <= nxt_idx;
                cnt       <= load_of(dur_tbl[nxt_idx]);
                lamps     <= nxt_lamps;
              end
            end
          end

          ST_CLEAR: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (clr_to_flash) begin
              state <= ST_FLASH;
              lamps <= FLASH_ON;
            end else begin
              state     <= ST_RUN;
              phase_idx <= '0;
              cnt       <= load_of(dur_tbl[0]);
              lamps     <= first_lamps;
            end
          end

          ST_FLASH: begin
            if (!flash_en) begin
              state        <= ST_CLEAR;
              cnt          <= CLR_LOAD;
              lamps        <= ALL_RED;
              clr_to_flash <= 1'b0;
            end else begin
              lamps <= (lamps == FLASH_ON) ? ALL_RED : FLASH_ON;
            end
          end

          default: state <= ST_INIT;
        endcase
      end
    end
  end

  assign L1_cmd = lamps.l1;
  assign L2_cmd = lamps.l2;
  assign L3_cmd = lamps.l3;

endmodule
